// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, depth and FSM state encoding for the memory responder.
// Contents: ADRS_W/DATA_W/DEPTH localparams and state_t {IDLE, WAIT, RESP}.
// Imported by mem_array and mem_responder.
package mem_pkg;

  localparam int ADRS_W = 15;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// mem_array: single-port synchronous 32k x 16 storage, read-first, no reset.
// Ports: clk (clock), we_en (write enable), adrs (word address),
//        din (write data), dout (registered read data of adrs, one edge later).
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we_en,
  input  logic [ADRS_W-1:0] adrs,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Contents deliberately have no reset; unwritten cells are undefined.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_en) begin
      mem[adrs] <= din;
    end
    dout <= mem[adrs];
  end

endmodule : mem_array

// File: rtl/mem_responder.sv
// mem_responder: tester-facing memory model, IDLE -> WAIT (WAIT_CYCLES+1) -> RESP handshake.
// Ports: clk, rst (async active-high), req/we/adrs/wdata (request, sampled in IDLE),
//        rdata (held read data), ack (one-cycle completion strobe), busy (access in progress).
// Optional macro STUCK_BIT_FAULT_EN: reads of FAULT_ADRS return bit FAULT_BIT forced to 1.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADRS_W-1:0] FAULT_ADRS  = 15'h1234,
  parameter int                FAULT_BIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADRS_W-1:0] adrs,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy
);

  // Elaboration-time parameter legality.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7 || FAULT_BIT < 0 || FAULT_BIT >= DATA_W ||
      int'(FAULT_ADRS) >= DEPTH) begin : g_param_check
    $error("mem_responder: illegal parameter value");
  end

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              busy_nxt;
  logic              ack_nxt;
  logic              capture;
  logic              mem_we;
  logic              rd_load;

  logic              we_q;
  logic [ADRS_W-1:0] adrs_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADRS_W-1:0] mem_adrs;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] rd_val;

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    ack_nxt   = 1'b0;
    capture   = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = WAIT;
          busy_nxt  = 1'b1;
          cnt_nxt   = WAIT_LOAD;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          // Edge entering RESP commits the access.
          state_nxt = RESP;
          ack_nxt   = 1'b1;
          mem_we    = we_q;
          rd_load   = ~we_q;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      busy  <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      ack   <= ack_nxt;
    end
  end

  // Capture registers; only meaningful once an access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      adrs_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= we;
      adrs_q  <= adrs;
      wdata_q <= wdata;
    end
  end

  // In IDLE the array is addressed straight from the request so its registered
  // output already holds mem[adrs] by the time WAIT ends, even for WAIT_CYCLES=0.
  // During WAIT the captured address keeps re-reading the same cell.
  assign mem_adrs = (state == IDLE) ? adrs : adrs_q;

  mem_array u_mem_array (
    .clk   (clk),
    .we_en (mem_we),
    .adrs  (mem_adrs),
    .din   (wdata_q),
    .dout  (mem_dout)
  );

`ifdef STUCK_BIT_FAULT_EN
  localparam logic [DATA_W-1:0] FAULT_MASK = DATA_W'(1) << FAULT_BIT;
  // Fault only corrupts the returned word; the stored cell is untouched.
  assign rd_val = (adrs_q == FAULT_ADRS) ? (mem_dout | FAULT_MASK) : mem_dout;
`else
  assign rd_val = mem_dout;
`endif

  // rdata changes only when a read completes; writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_load) begin
      rdata <= rd_val;
    end
  end

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [14:0] adrs;
  logic [15:0] wdata;

  logic [15:0] rdata, rdata_w0, rdata_w7;
  logic        ack, ack_w0, ack_w7;
  logic        busy, busy_w0, busy_w7;

  int checks = 0;
  int errors = 0;

  mem_responder #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .adrs(adrs), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .adrs(adrs), .wdata(wdata),
    .rdata(rdata_w0), .ack(ack_w0), .busy(busy_w0)
  );

  mem_responder #(.WAIT_CYCLES(7)) u_w7 (
    .clk(clk), .rst(rst), .req(req), .we(we), .adrs(adrs), .wdata(wdata),
    .rdata(rdata_w7), .ack(ack_w7), .busy(busy_w7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One access on u_dut: req held until ack is seen; latency counted in
  // falling edges after the sampling edge (ack-high cycle = WAIT_CYCLES+2).
  task automatic access(input string tag, input logic w, input logic [14:0] a,
                        input logic [15:0] d, output logic [15:0] rd);
    int lat;
    @(negedge clk);
    req = 1'b1; we = w; adrs = a; wdata = d;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (ack) break;
    end
    rd  = rdata;
    req = 1'b0;
    chkint({tag, "_latency"}, lat, 3);
  endtask

  logic [15:0] rd;
  int n_ack, t1, t2, extra;
  int l0, l1, l7;

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; adrs = '0; wdata = '0;
    #1 rst = 1'b1;
    #1;
    chk1 ("reset_busy",  busy, 1'b0);
    chk1 ("reset_ack",   ack, 1'b0);
    chk16("reset_rdata", rdata, 16'h0000);
    chk1 ("reset_busy_w7", busy_w7, 1'b0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with req low: nothing moves.
    repeat (3) @(negedge clk);
    chk1 ("idle_busy",  busy, 1'b0);
    chk1 ("idle_ack",   ack, 1'b0);
    chk16("idle_rdata", rdata, 16'h0000);

    access("wr_0000", 1'b1, 15'h0000, 16'hAAAA, rd);
    chk16("wr_keeps_rdata", rd, 16'h0000);
    access("rd_0000", 1'b0, 15'h0000, 16'h0000, rd);
    chk16("rd_0000_data", rd, 16'hAAAA);

    access("wr_7fff", 1'b1, 15'h7FFF, 16'h7FFF, rd);
    chk16("wr_7fff_keeps_rdata", rd, 16'hAAAA);
    access("rd_7fff", 1'b0, 15'h7FFF, 16'h0000, rd);
    chk16("rd_7fff_data", rd, 16'h7FFF);

    access("wr_0005", 1'b1, 15'h0005, 16'hBEEF, rd);
    access("rd_0005", 1'b0, 15'h0005, 16'h0000, rd);
    chk16("raw_0005_data", rd, 16'hBEEF);
    access("ow_0000", 1'b1, 15'h0000, 16'h0F0F, rd);
    access("rd_0000b", 1'b0, 15'h0000, 16'h0000, rd);
    chk16("overwrite_0000_data", rd, 16'h0F0F);
    chk16("rdata_held_idle", rdata, 16'h0F0F);

    // req held high across two accesses.
    @(negedge clk);
    req = 1'b1; we = 1'b0; adrs = 15'h7FFF;
    n_ack = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ack) begin
        n_ack++;
        if (n_ack == 1) t1 = i;
        else t2 = i;
        if (n_ack == 2) break;
      end
    end
    req = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) extra++;
    end
    chkint("held_ack_count", n_ack, 2);
    chkint("held_first_ack", t1, 3);
    chkint("held_ack_spacing", t2 - t1, 4);
    chkint("held_no_extra_ack", extra, 0);
    chk16 ("held_rdata", rdata, 16'h7FFF);

    // Reset during WAIT aborts the write.
    access("wr_0010", 1'b1, 15'h0010, 16'h1111, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b1; adrs = 15'h0010; wdata = 16'h5555;
    @(negedge clk);
    chk1("abort_busy_in_wait", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1 ("abort_busy_now",  busy, 1'b0);
    chk1 ("abort_ack_now",   ack, 1'b0);
    chk16("abort_rdata_now", rdata, 16'h0000);
    req = 1'b0;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) extra++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack) extra++;
    end
    chkint("abort_no_ack", extra, 0);
    access("rd_0010", 1'b0, 15'h0010, 16'h0000, rd);
    chk16("abort_rd_0010", rd, 16'h1111);

    // Stuck-bit fault overlay.
    access("wr_1234", 1'b1, 15'h1234, 16'h0000, rd);
    access("rd_1234", 1'b0, 15'h1234, 16'h0000, rd);
`ifdef STUCK_BIT_FAULT_EN
    chk16("fault_rd_1234", rd, 16'h0001);
`else
    chk16("fault_rd_1234", rd, 16'h0000);
`endif
    access("wr_1235", 1'b1, 15'h1235, 16'h0000, rd);
    access("rd_1235", 1'b0, 15'h1235, 16'h0000, rd);
    chk16("fault_rd_1235", rd, 16'h0000);

    // WAIT_CYCLES sweep: one-cycle req seen by all three instances at once.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; adrs = 15'h0000;
    l0 = 0; l1 = 0; l7 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (ack_w0 && l0 == 0) l0 = i;
      if (ack    && l1 == 0) l1 = i;
      if (ack_w7 && l7 == 0) l7 = i;
    end
    chkint("sweep_w0_latency", l0, 2);
    chkint("sweep_w1_latency", l1, 3);
    chkint("sweep_w7_latency", l7, 9);
    chk16 ("sweep_w0_rdata", rdata_w0, 16'h0F0F);
    chk1  ("sweep_w7_idle_busy", busy_w7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_responder
